// File: rtl/clk_div_pkg.sv
// Shared types, defaults and ratio helpers for the clock-ratio detector.
// The helpers take a 16-bit value, so callers zero-extend counters of any width up to 16 bits.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEAS,
      LOCKED
   } state_t;

   localparam int CNT_W_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;
   localparam int CNT_W_MAX    = 16;

   function automatic logic f_is_pow2(input logic [CNT_W_MAX-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Index of the highest set bit; for a power of two this is exactly log2.
   function automatic logic [3:0] f_log2(input logic [CNT_W_MAX-1:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < CNT_W_MAX; i++) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus rising-edge detect.
// The rise output is combinational off the last two synchronized samples.
module sync_edge_det
   import clk_div_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic din,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else if (clr) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         s_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev;

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures the rise-to-rise period and high time of a divided clock in clk cycles,
// reports power-of-two ratios, declares lock on stable ratios and flags lost edges.
module clk_ratio_detector
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int LOCK_CNT    = LOCK_CNT_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   input  logic             clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] duty_high,
   output logic             period_valid,
   output logic             is_pow2,
   output logic [3:0]       ratio_log2,
   output logic             locked,
   output logic             timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] MAX    = '1;
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);
   localparam logic [MW-1:0]    M_ONE  = MW'(1);

   logic s;
   logic rise;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .din (div_in),
      .s   (s),
      .rise(rise)
   );

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] hcnt, hcnt_n;
   logic [MW-1:0]    match_cnt, match_n;
   logic [CNT_W-1:0] period_n, duty_n;
   logic             valid_n, pow2_n, locked_n, timeout_n;
   logic [3:0]       log2_n;
   logic [CNT_W_MAX-1:0] cnt_ext;

   assign cnt_ext = CNT_W_MAX'(cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         hcnt         <= '0;
         match_cnt    <= '0;
         period       <= '0;
         duty_high    <= '0;
         period_valid <= 1'b0;
         is_pow2      <= 1'b0;
         ratio_log2   <= '0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         hcnt         <= hcnt_n;
         match_cnt    <= match_n;
         period       <= period_n;
         duty_high    <= duty_n;
         period_valid <= valid_n;
         is_pow2      <= pow2_n;
         ratio_log2   <= log2_n;
         locked       <= locked_n;
         timeout      <= timeout_n;
      end
   end

   // A nonzero match_cnt doubles as "a previous measurement exists since arming".
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hcnt_n    = hcnt;
      match_n   = match_cnt;
      period_n  = period;
      duty_n    = duty_high;
      valid_n   = 1'b0;
      pow2_n    = is_pow2;
      log2_n    = ratio_log2;
      locked_n  = locked;
      timeout_n = timeout;

      if (clr) begin
         state_n   = IDLE;
         cnt_n     = '0;
         hcnt_n    = '0;
         match_n   = '0;
         period_n  = '0;
         duty_n    = '0;
         pow2_n    = 1'b0;
         log2_n    = '0;
         locked_n  = 1'b0;
         timeout_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt_n  = '0;
               hcnt_n = '0;
               if (rise) begin
                  state_n   = MEAS;
                  cnt_n     = ONE;
                  hcnt_n    = ONE;
                  match_n   = '0;
                  timeout_n = 1'b0;
               end
            end
            MEAS, LOCKED: begin
               if (rise) begin
                  period_n = cnt;
                  duty_n   = hcnt;
                  valid_n  = 1'b1;
                  pow2_n   = f_is_pow2(cnt_ext);
                  log2_n   = f_is_pow2(cnt_ext) ? f_log2(cnt_ext) : 4'd0;
                  if ((match_cnt != '0) && (cnt == period)) begin
                     match_n = (match_cnt >= LOCK_V) ? match_cnt : match_cnt + 1'b1;
                  end else begin
                     match_n = M_ONE;
                  end
                  locked_n = (match_n >= LOCK_V);
                  state_n  = locked_n ? LOCKED : MEAS;
                  cnt_n    = ONE;
                  hcnt_n   = ONE;
               end else if (cnt == MAX) begin
                  state_n   = IDLE;
                  cnt_n     = '0;
                  hcnt_n    = '0;
                  match_n   = '0;
                  period_n  = '0;
                  duty_n    = '0;
                  pow2_n    = 1'b0;
                  log2_n    = '0;
                  locked_n  = 1'b0;
                  timeout_n = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
                  if (s && (hcnt != MAX)) hcnt_n = hcnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Scoreboard bench: div_in pulse trains are generated with known high/low lengths and the
// expected measurements are derived from those lengths, then matched against period_valid.
module tb_clk_ratio_detector;

   localparam int CNT_W       = 8;
   localparam int LOCK_CNT    = 4;
   localparam int SYNC_STAGES = 2;
   localparam int MAXV        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             div_in;
   logic             clr;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] duty_high;
   logic             period_valid;
   logic             is_pow2;
   logic [3:0]       ratio_log2;
   logic             locked;
   logic             timeout;

   clk_ratio_detector #(
      .CNT_W      (CNT_W),
      .LOCK_CNT   (LOCK_CNT),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .div_in      (div_in),
      .clr         (clr),
      .period      (period),
      .duty_high   (duty_high),
      .period_valid(period_valid),
      .is_pow2     (is_pow2),
      .ratio_log2  (ratio_log2),
      .locked      (locked),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int period;
      int duty;
      int pow2;
      int lg;
      int lck;
   } exp_t;

   exp_t sb[$];
   int   hist[$];
   bit   armed = 1'b0;
   int   prev_h = 0;
   int   prev_l = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;

   task automatic check_val(input string name, input int act, input int exp);
      n_compared++;
      if (act != exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_log2(input int p);
      for (int k = 0; k < 16; k++) begin
         if (p == (1 << k)) return k;
      end
      return -1;
   endfunction

   // A rise of div_in closes the previous pulse, whose length is the measured period.
   task automatic model_rise(input int h, input int l);
      exp_t e;
      int   p, run, lg;
      if (armed) begin
         p = prev_h + prev_l;
         hist.push_back(p);
         run = 1;
         for (int i = hist.size() - 2; i >= 0; i--) begin
            if (hist[i] != p) break;
            run++;
         end
         lg       = model_log2(p);
         e.period = p;
         e.duty   = prev_h;
         e.pow2   = (lg >= 0) ? 1 : 0;
         e.lg     = (lg >= 0) ? lg : 0;
         e.lck    = (run >= LOCK_CNT) ? 1 : 0;
         sb.push_back(e);
      end
      armed  = 1'b1;
      prev_h = h;
      prev_l = l;
   endtask

   task automatic model_disarm();
      armed = 1'b0;
      hist.delete();
   endtask

   task automatic drive_pulse(input int h, input int l);
      model_rise(h, l);
      div_in = 1'b1;
      repeat (h) @(negedge clk);
      div_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_period"}, int'(period), 0);
      check_val({tag, "_duty"}, int'(duty_high), 0);
      check_val({tag, "_valid"}, int'(period_valid), 0);
      check_val({tag, "_pow2"}, int'(is_pow2), 0);
      check_val({tag, "_log2"}, int'(ratio_log2), 0);
      check_val({tag, "_locked"}, int'(locked), 0);
      check_val({tag, "_timeout"}, int'(timeout), 0);
   endtask

   // Monitor: every period_valid pulse consumes one expected measurement.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && period_valid) begin
         n_compared++;
         if (sb.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_valid: got period=%0d expected no measurement", period);
         end else begin
            e = sb.pop_front();
            if (int'(period) != e.period || int'(duty_high) != e.duty || int'(is_pow2) != e.pow2 ||
                int'(ratio_log2) != e.lg || int'(locked) != e.lck) begin
               n_mismatched++;
               $display("[TB] FAIL measurement: got p=%0d h=%0d pow2=%0d lg=%0d lock=%0d expected p=%0d h=%0d pow2=%0d lg=%0d lock=%0d",
                        period, duty_high, is_pow2, ratio_log2, locked,
                        e.period, e.duty, e.pow2, e.lg, e.lck);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int h, l, reps;
      rst    = 1'b1;
      clr    = 1'b0;
      div_in = 1'b0;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // clk/4, then an asynchronous reset in the middle of a high phase
      repeat (7) drive_pulse(2, 2);
      model_rise(2, 2);
      div_in = 1'b1;
      @(negedge clk);
      #3 rst = 1'b1;
      #1 check_zero("async_rst");
      sb.delete();
      model_disarm();
      div_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // clk/6; the first rise after reset only arms
      repeat (7) drive_pulse(3, 3);

      // clk/8 locked, then switch to clk/16
      repeat (6) drive_pulse(4, 4);
      repeat (6) drive_pulse(8, 8);

      // longest measurable period: rise coincides with a saturated counter
      repeat (2) drive_pulse(1, MAXV - 1);
      repeat (6) drive_pulse(4, 4);

      // timeout: last rise, then div_in held low
      model_rise(2, 0);
      div_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      div_in = 1'b0;
      repeat (255) @(negedge clk);
      check_val("timeout_early", int'(timeout), 0);
      @(negedge clk);
      check_val("timeout_set", int'(timeout), 1);
      check_val("timeout_locked", int'(locked), 0);
      check_val("timeout_period", int'(period), 0);
      check_val("timeout_log2", int'(ratio_log2), 0);
      model_disarm();
      repeat (5) @(negedge clk);
      model_rise(3, 3);
      div_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("timeout_held", int'(timeout), 1);
      @(negedge clk);
      check_val("timeout_cleared", int'(timeout), 0);
      div_in = 1'b0;
      repeat (3) @(negedge clk);
      repeat (5) drive_pulse(3, 3);

      // synchronous clear while locked, then relock
      check_val("locked_before_clr", int'(locked), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check_zero("clr");
      model_disarm();
      repeat (3) @(negedge clk);
      repeat (6) drive_pulse(5, 5);
      check_val("relocked", int'(locked), 1);

      // randomized ratio groups
      for (int g = 0; g < 20; g++) begin
         h    = int'($urandom_range(1, 12));
         l    = int'($urandom_range(1, 12));
         reps = int'($urandom_range(1, 7));
         for (int r = 0; r < reps; r++) drive_pulse(h, l);
      end

      drive_pulse(2, 2);
      repeat (10) @(negedge clk);
      check_val("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
